machine_keypad_scan: RTL and testbench

//  Input-side counterpart of the Machine display path. It scans a 4x4 active-low

---
 rtl/machine_keypad_scan.sv | 131 +++++++++++++
 tb/tb_machine_keypad_scan.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/machine_keypad_scan.sv
// 4x4 active-low matrix keypad scanner: synchronise, scan, debounce per full scan,
// and emit one event per accepted key while shifting hex digits into a 32-bit word.
module machine_keypad_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] word
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_col;
    logic [15:0]       r_snap;
    logic [15:0]       r_prev;
    logic [STAB_W-1:0] r_stab;
    logic              r_done;
    logic [0:0]        r_state;
    logic              r_key_valid;
    logic [3:0]        r_key_code;
    logic [31:0]       r_word;

    logic [3:0]  w_pressed;
    logic        w_slot_end;
    logic        w_scan_end;
    logic [15:0] w_snap_next;
    logic        w_stable;
    logic        w_accept;
    logic [3:0]  w_index;

    function automatic logic [3:0] f_bit_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign w_pressed  = ~r_sync2;
    assign w_slot_end = (r_div == DIV_LAST);
    assign w_scan_end = w_slot_end && (r_col == 2'd3);
    assign w_stable   = (r_stab == STAB_MAX);
    assign w_index    = f_bit_index(r_prev);
    assign w_accept   = r_done && w_stable && (r_state == S_IDLE) && $onehot(r_prev);

    // The current column's rows land at bit row*4+col of the snapshot.
    always_comb begin
        w_snap_next = r_snap;
        for (int r = 0; r < 4; r++) begin
            w_snap_next[{2'(r), r_col}] = w_pressed[r];
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_div   <= '0;
            r_col   <= 2'd0;
        end else begin
            r_sync1 <= rows;
            r_sync2 <= r_sync1;
            r_div   <= w_slot_end ? '0 : r_div + 1'b1;
            if (w_slot_end) r_col <= r_col + 2'd1;
        end
    end

    // Debounce counts consecutive identical full-scan snapshots.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_snap <= 16'h0;
            r_prev <= 16'h0;
            r_stab <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_scan_end;
            if (w_slot_end) r_snap <= w_snap_next;
            if (w_scan_end) begin
                if (w_snap_next == r_prev)
                    r_stab <= w_stable ? STAB_MAX : r_stab + 1'b1;
                else
                    r_stab <= STAB_W'(1);
                r_prev <= w_snap_next;
            end
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            r_state     <= S_IDLE;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_word      <= 32'h0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_accept) begin
                r_state     <= S_HELD;
                r_key_valid <= 1'b1;
                r_key_code  <= w_index;
            end else if (r_done && w_stable && (r_state == S_HELD) && (r_prev == 16'h0)) begin
                r_state <= S_IDLE;
            end
            // clr outranks a coinciding digit shift.
            if (clr)
                r_word <= 32'h0;
            else if (w_accept)
                r_word <= {r_word[27:0], w_index};
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign word      = r_word;

endmodule

// File: tb/tb_machine_keypad_scan.sv
// Scoreboard bench: a keypad model drives rows from cols; a per-scan reference
// model predicts key events, which a monitor compares against the DUT outputs.
module tb_machine_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] word;
    logic [15:0] keys;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] word;
    } exp_t;

    exp_t        q[$];
    logic [15:0] hist[$];
    bit          m_held;
    logic [31:0] m_word;
    int          checks;
    int          errors;
    int          ev_cnt;

    machine_keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .system1000      (clk),
        .system1000_rstn (rst_n),
        .rows            (rows),
        .cols            (cols),
        .clr             (clr),
        .key_valid       (key_valid),
        .key_code        (key_code),
        .word            (word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column line.
    always_comb begin
        for (int r = 0; r < 4; r++)
            rows[r] = ~(|(keys[r*4 +: 4] & ~cols));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_stable();
        if (hist.size() < DEBOUNCE) return 0;
        for (int i = 1; i < DEBOUNCE; i++)
            if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 0;
        return 1;
    endfunction

    // Evaluate the most recently completed scan, with clr as seen on that cycle.
    task automatic model_accept(input bit c);
        bit          ev;
        logic [3:0]  code;
        logic [15:0] last;
        exp_t        e;
        ev   = 0;
        code = 4'd0;
        if (hist.size() > 0 && m_stable()) begin
            last = hist[hist.size()-1];
            if (!m_held && $countones(last) == 1) begin
                for (int i = 0; i < 16; i++) if (last[i]) code = 4'(i);
                ev     = 1;
                m_held = 1;
            end else if (m_held && last == 16'h0) begin
                m_held = 0;
            end
        end
        if (c) m_word = 32'h0;
        else if (ev) m_word = {m_word[27:0], code};
        if (ev) begin
            e.code = code;
            e.word = m_word;
            q.push_back(e);
        end
    endtask

    task automatic model_end_scan(input logic [15:0] k);
        hist.push_back(k);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
    endtask

    // Called at a negedge in the first cycle of a scan; returns at the next scan start.
    task automatic do_scan(input logic [15:0] k, input bit c);
        keys = k;
        clr  = c;
        model_accept(c);
        @(negedge clk);
        clr = 1'b0;
        repeat (4*SCAN_DIV - 1) @(negedge clk);
        model_end_scan(k);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && key_valid) begin
            ev_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_key_valid: got code %h word %h expected no event", key_code, word);
            end else begin
                e = q.pop_front();
                check("event_code", {28'h0, key_code}, {28'h0, e.code});
                check("event_word", word, e.word);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0;
        int          kind;
        int          dur;
        logic [15:0] k;
        checks = 0; errors = 0; ev_cnt = 0;
        m_held = 0; m_word = 32'h0;
        rst_n = 1'b0; clr = 1'b0; keys = 16'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_cols", {28'h0, cols}, 32'hE);
        check("reset_key_valid", {31'h0, key_valid}, 32'h0);
        check("reset_key_code", {28'h0, key_code}, 32'h0);
        check("reset_word", word, 32'h0);
        repeat (SCAN_DIV) @(negedge clk);
        check("cols_slot1", {28'h0, cols}, 32'hD);
        repeat (3*SCAN_DIV) @(negedge clk);
        check("cols_wrap", {28'h0, cols}, 32'hE);
        model_end_scan(16'h0);

        // Single held key, no auto-repeat.
        e0 = ev_cnt;
        repeat (6) do_scan(16'h0040, 0);
        repeat (3) do_scan(16'h0000, 0);
        check("hold_event_count", 32'(ev_cnt - e0), 32'd1);
        check("hold_key_code", {28'h0, key_code}, 32'h6);
        check("hold_word", word, 32'h00000006);

        // Bouncing key never settles.
        e0 = ev_cnt;
        for (int i = 0; i < 10; i++) do_scan((i % 2 == 0) ? 16'h0100 : 16'h0000, 0);
        repeat (3) do_scan(16'h0000, 0);
        check("toggle_no_event", 32'(ev_cnt - e0), 32'd0);

        // Chord is ignored; lone survivor is accepted.
        e0 = ev_cnt;
        repeat (4) do_scan(16'h0021, 0);
        check("chord_no_event", 32'(ev_cnt - e0), 32'd0);
        repeat (4) do_scan(16'h0001, 0);
        repeat (3) do_scan(16'h0000, 0);
        check("chord_release_event", 32'(ev_cnt - e0), 32'd1);
        check("chord_key_code", {28'h0, key_code}, 32'h0);

        // Digit entry and nibble shift with overflow.
        do_scan(16'h0000, 1);
        for (int d = 1; d <= 3; d++) begin
            repeat (3) do_scan(16'(1 << d), 0);
            repeat (3) do_scan(16'h0000, 0);
        end
        check("word_123", word, 32'h00000123);
        for (int d = 4; d <= 9; d++) begin
            repeat (3) do_scan(16'(1 << d), 0);
            repeat (3) do_scan(16'h0000, 0);
        end
        check("word_wrap", word, 32'h23456789);

        // clr coinciding with acceptance.
        e0 = ev_cnt;
        do_scan(16'h0400, 0);
        do_scan(16'h0400, 0);
        do_scan(16'h0400, 1);
        repeat (3) do_scan(16'h0000, 0);
        check("clr_event_count", 32'(ev_cnt - e0), 32'd1);
        check("clr_key_code", {28'h0, key_code}, 32'hA);
        check("clr_word", word, 32'h0);

        // Randomised key activity.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            dur  = int'($urandom_range(1, 4));
            k    = 16'h0;
            if (kind <= 5) k = 16'(1 << $urandom_range(0, 15));
            else if (kind == 8) k = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            for (int s = 0; s < dur; s++) begin
                if (kind == 9) k = 16'($urandom) & 16'($urandom);
                do_scan(k, $urandom_range(0, 15) == 0);
            end
        end
        repeat (4) do_scan(16'h0000, 0);
        check("queue_drained", 32'(q.size()), 32'd0);
        check("final_word", word, m_word);

        // Reset in the middle of a slot.
        repeat (3) do_scan(16'h8000, 0);
        do_scan(16'h0000, 0);
        check("pre_reset_code", {28'h0, key_code}, 32'hF);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_cols", {28'h0, cols}, 32'hE);
        check("midreset_key_valid", {31'h0, key_valid}, 32'h0);
        check("midreset_key_code", {28'h0, key_code}, 32'h0);
        check("midreset_word", word, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
